// File: rtl/fir_sample_scheduler_if.sv
// Bundles the scheduler's stream, sample-buffer, engine, result and watchdog signals.
// master: scheduler side; slave: environment side (source, buffer, engine, consumer).
//   sample_in/sample_valid/sample_ready : input sample stream
//   buf_we/buf_waddr/buf_wdata          : circular sample-buffer write port
//   base_ptr/fir_start/fir_done/fir_result : FIR engine control and result
//   y_out/y_valid/y_ready               : result FIFO output stream
//   fir_timeout/timeout_clr             : sticky watchdog flag and its clear
interface fir_sample_scheduler_if #(
  parameter int unsigned BufAw = 14
);
  logic [17:0]      sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic             buf_we;
  logic [BufAw-1:0] buf_waddr;
  logic [17:0]      buf_wdata;
  logic [BufAw-1:0] base_ptr;
  logic             fir_start;
  logic             fir_done;
  logic [17:0]      fir_result;
  logic [17:0]      y_out;
  logic             y_valid;
  logic             y_ready;
  logic             fir_timeout;
  logic             timeout_clr;

  modport master (
    input  sample_in, sample_valid, fir_done, fir_result, y_ready, timeout_clr,
    output sample_ready, buf_we, buf_waddr, buf_wdata, base_ptr, fir_start,
           y_out, y_valid, fir_timeout
  );

  modport slave (
    output sample_in, sample_valid, fir_done, fir_result, y_ready, timeout_clr,
    input  sample_ready, buf_we, buf_waddr, buf_wdata, base_ptr, fir_start,
           y_out, y_valid, fir_timeout
  );
endinterface

// File: rtl/fir_sample_scheduler.sv
// Front-end sequencer for the FIR MAC engine: accepts one sample, writes it into the
// circular sample buffer, starts the engine, and queues the result in a small FIFO.
// A watchdog aborts a computation that does not finish within Timeout BUSY cycles.
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : fir_sample_scheduler_if.master (stream in, buffer write, engine, results out)
module fir_sample_scheduler #(
  parameter int unsigned BufAw     = 14,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned Timeout   = 4200
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  fir_sample_scheduler_if.master   bus
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(Timeout - 1);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {StIdle, StWrite, StStart, StBusy} state_e;

  state_e           state_q, state_d;
  logic [17:0]      sample_q, sample_d;
  logic [BufAw-1:0] wptr_q, wptr_d;
  logic [BufAw-1:0] base_q, base_d;
  logic [CntW-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;

  logic [17:0]      mem_q [FifoDepth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q, cnt_d;

  logic push, pop, timeout_set, ready;

  // Ready only with room for the result of the one computation about to start.
  assign ready = (state_q == StIdle) && (cnt_q < FullCnt);
  assign pop   = (cnt_q != '0) && bus.y_ready;

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    wptr_d      = wptr_q;
    base_d      = base_q;
    wd_cnt_d    = wd_cnt_q;
    push        = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.sample_valid && ready) begin
          sample_d = bus.sample_in;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        base_d  = wptr_q;
        wptr_d  = wptr_q + 1'b1;
        state_d = StStart;
      end
      StStart: begin
        wd_cnt_d = '0;
        state_d  = StBusy;
      end
      StBusy: begin
        // A result on the terminal cycle still counts as a completion.
        if (bus.fir_done) begin
          push    = 1'b1;
          state_d = StIdle;
        end else if (wd_cnt_q == TermCnt) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (bus.timeout_clr) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      sample_q  <= '0;
      wptr_q    <= '0;
      base_q    <= '0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      wptr_q    <= wptr_d;
      base_q    <= base_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= bus.fir_result;
    end
  end

  assign bus.sample_ready = ready;
  assign bus.buf_we       = (state_q == StWrite);
  assign bus.buf_waddr    = wptr_q;
  assign bus.buf_wdata    = sample_q;
  assign bus.base_ptr     = base_q;
  assign bus.fir_start    = (state_q == StStart);
  assign bus.y_valid      = (cnt_q != '0);
  assign bus.y_out        = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.fir_timeout  = timeout_q;

endmodule

// File: tb/tb_fir_sample_scheduler.sv
module tb_fir_sample_scheduler;
  localparam int unsigned BufAw     = 4;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned Timeout   = 4200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_sample_scheduler_if #(.BufAw(BufAw)) bus ();

  fir_sample_scheduler #(
    .BufAw    (BufAw),
    .FifoDepth(FifoDepth),
    .Timeout  (Timeout)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q [$];
  logic [BufAw-1:0] exp_wptr = '0;
  logic pop_on_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: checks every pop against the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > FifoDepth) begin
        bad++;
        $display("FAIL fifo_overflow: depth %0d exceeds %0d", exp_q.size(), FifoDepth);
      end
      if (!rst && bus.y_valid && bus.y_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h expected no output", bus.y_out);
        end else begin
          chk("y_out", 32'(bus.y_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  // lat < 0: engine never answers. Otherwise fir_done arrives lat cycles after fir_start.
  task automatic send(input logic [17:0] s, input logic [17:0] r, input int lat);
    int w = 0;
    @(negedge clk);
    while (!bus.sample_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.sample_ready) begin
      chk("ready_wait", 32'(bus.sample_ready), 32'd1);
      return;
    end
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    @(negedge clk);
    chk("buf_we", 32'(bus.buf_we), 32'd1);
    chk("buf_waddr", 32'(bus.buf_waddr), 32'(exp_wptr));
    chk("buf_wdata", 32'(bus.buf_wdata), 32'(s));
    chk("start_early", 32'(bus.fir_start), 32'd0);
    @(negedge clk);
    chk("fir_start", 32'(bus.fir_start), 32'd1);
    chk("buf_we_width", 32'(bus.buf_we), 32'd0);
    chk("base_ptr", 32'(bus.base_ptr), 32'(exp_wptr));
    exp_wptr = exp_wptr + 1'b1;
    if (lat >= 0) begin
      repeat (lat) @(posedge clk);
      #1;
      bus.fir_done   = 1'b1;
      bus.fir_result = r;
      exp_q.push_back(r);
      if (pop_on_done) bus.y_ready = 1'b1;
      @(posedge clk);
      #1 bus.fir_done = 1'b0;
      if (pop_on_done) bus.y_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    bus.y_ready = 1'b1;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("empty_after_drain", 32'(bus.y_valid), 32'd0);
    bus.y_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_wptr = '0;
  endtask

  initial begin
    int hits;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.fir_done     = 1'b0;
    bus.fir_result   = '0;
    bus.y_ready      = 1'b0;
    bus.timeout_clr  = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(bus.sample_ready), 32'd1);
    chk("rst_buf_we", 32'(bus.buf_we), 32'd0);
    chk("rst_waddr", 32'(bus.buf_waddr), 32'd0);
    chk("rst_start", 32'(bus.fir_start), 32'd0);
    chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
    chk("rst_y_out", 32'(bus.y_out), 32'd0);
    chk("rst_timeout", 32'(bus.fir_timeout), 32'd0);

    // Single sample, engine answers 3 cycles after fir_start
    send(18'h00123, 18'h00456, 3);
    @(negedge clk);
    chk("t1_y_valid", 32'(bus.y_valid), 32'd1);
    chk("t1_y_out", 32'(bus.y_out), 32'h456);
    chk("t1_base_ptr", 32'(bus.base_ptr), 32'd0);
    chk("t1_ready", 32'(bus.sample_ready), 32'd1);
    drain();

    // Pointer wrap: 2^BufAw+2 samples from address 0
    do_reset();
    bus.y_ready = 1'b1;
    for (int i = 0; i < (1 << BufAw) + 2; i++) begin
      send(18'(i * 3 + 1), 18'(i * 3 + 2), 1);
    end
    drain();
    chk("wrap_wptr_model", 32'(exp_wptr), 32'd2);

    // FIFO fill with consumer stalled: 4 accepted, 5th offer blocked
    for (int i = 0; i < 4; i++) begin
      send(18'(18'h100 + i), 18'(18'h3F000 + i), 2);
    end
    @(negedge clk);
    bus.sample_in    = 18'h00777;
    bus.sample_valid = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sample_ready || bus.buf_we) hits++;
    end
    bus.sample_valid = 1'b0;
    chk("full_blocks", 32'(hits), 32'd0);
    chk("full_y_out", 32'(bus.y_out), 32'h3F000);
    drain();
    send(18'h00777, 18'h00888, 2);
    send(18'h00999, 18'h00AAA, 2);
    drain();

    // Watchdog: engine silent, set beats a simultaneous clear
    send(18'h01234, 18'h0, -1);
    repeat (Timeout) @(negedge clk);
    chk("wd_before", 32'(bus.fir_timeout), 32'd0);
    chk("wd_busy", 32'(bus.sample_ready), 32'd0);
    bus.timeout_clr = 1'b1;
    @(negedge clk);
    bus.timeout_clr = 1'b0;
    chk("wd_set", 32'(bus.fir_timeout), 32'd1);
    chk("wd_idle", 32'(bus.sample_ready), 32'd1);
    chk("wd_no_push", 32'(bus.y_valid), 32'd0);
    @(negedge clk);
    chk("wd_sticky", 32'(bus.fir_timeout), 32'd1);
    bus.timeout_clr = 1'b1;
    @(negedge clk);
    bus.timeout_clr = 1'b0;
    chk("wd_clr", 32'(bus.fir_timeout), 32'd0);
    bus.fir_done   = 1'b1;
    bus.fir_result = 18'h2BAD0;
    @(negedge clk);
    bus.fir_done = 1'b0;
    @(negedge clk);
    chk("late_done_y_valid", 32'(bus.y_valid), 32'd0);
    chk("late_done_ready", 32'(bus.sample_ready), 32'd1);

    // Result on exactly the terminal BUSY cycle
    send(18'h02222, 18'h03333, Timeout);
    @(negedge clk);
    chk("term_no_flag", 32'(bus.fir_timeout), 32'd0);
    chk("term_y_out", 32'(bus.y_out), 32'h03333);
    drain();

    // Simultaneous push and pop with two entries queued
    send(18'h00011, 18'h10001, 1);
    send(18'h00022, 18'h10002, 1);
    pop_on_done = 1'b1;
    send(18'h00033, 18'h10003, 1);
    pop_on_done = 1'b0;
    @(negedge clk);
    chk("pushpop_count", 32'(dut.cnt_q), 32'd2);
    chk("pushpop_head", 32'(bus.y_out), 32'h10002);
    drain();

    // Reset during BUSY with a result still queued
    send(18'h00044, 18'h10004, 1);
    send(18'h00055, 18'h0, -1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_wptr = '0;
    chk("rb_ready", 32'(bus.sample_ready), 32'd1);
    chk("rb_buf_we", 32'(bus.buf_we), 32'd0);
    chk("rb_waddr", 32'(bus.buf_waddr), 32'd0);
    chk("rb_wdata", 32'(bus.buf_wdata), 32'd0);
    chk("rb_base", 32'(bus.base_ptr), 32'd0);
    chk("rb_y_valid", 32'(bus.y_valid), 32'd0);
    chk("rb_y_out", 32'(bus.y_out), 32'd0);
    bus.fir_done   = 1'b1;
    bus.fir_result = 18'h1DEAD;
    @(negedge clk);
    bus.fir_done = 1'b0;
    @(negedge clk);
    chk("rb_late_done", 32'(bus.y_valid), 32'd0);
    send(18'h00066, 18'h10006, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
